// File: rtl/arkanoid_pkg.sv
// ---------------------------------------------------------------------------
// arkanoid_pkg
// Shared definitions for the brick-map side of the game:
//   - brick-map command codes (FUNC_*)
//   - default map geometry (ROWS_DEF / COLS_DEF)
//   - brick_hit_ctrl FSM state encoding
//   - saturating brick-count decrement helper
// ---------------------------------------------------------------------------
package arkanoid_pkg;

    typedef logic [1:0] map_func_t;

    localparam map_func_t FUNC_CLEAR    = 2'b00;
    localparam map_func_t FUNC_LOAD     = 2'b01;
    localparam map_func_t FUNC_DROPDOWN = 2'b10;
    localparam map_func_t FUNC_PUSHUP   = 2'b11;

    localparam int ROWS_DEF = 10;
    localparam int COLS_DEF = 20;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_H_RD  = 3'd1;
    localparam logic [2:0] ST_H_CHK = 3'd2;
    localparam logic [2:0] ST_H_CLR = 3'd3;
    localparam logic [2:0] ST_V_RD  = 3'd4;
    localparam logic [2:0] ST_V_CHK = 3'd5;
    localparam logic [2:0] ST_V_CLR = 3'd6;
    localparam logic [2:0] ST_DONE  = 3'd7;

    // Brick count never wraps below zero.
    function automatic logic [8:0] sat_dec(input logic [8:0] v);
        return (v == 9'd0) ? 9'd0 : v - 9'd1;
    endfunction

endpackage

// File: rtl/cell_locator.sv
// ---------------------------------------------------------------------------
// cell_locator
// Combinational pixel-to-cell mapping for the brick map.
// Ports:
//   px, py  in   11-bit signed pixel point
//   row     out  map row (0 when invalid)
//   col     out  map column (0 when invalid)
//   valid   out  point lies inside the grid
// ---------------------------------------------------------------------------
module cell_locator #(
    parameter int ROWS     = 10,
    parameter int COLS     = 20,
    parameter int CELL_W   = 16,
    parameter int CELL_H   = 8,
    parameter int ORIGIN_X = 0,
    parameter int ORIGIN_Y = 0
) (
    input  logic signed [10:0] px,
    input  logic signed [10:0] py,
    output logic        [3:0]  row,
    output logic        [4:0]  col,
    output logic               valid
);

    localparam int SH_X = $clog2(CELL_W);
    localparam int SH_Y = $clog2(CELL_H);

    localparam logic signed [10:0] OX    = 11'(ORIGIN_X);
    localparam logic signed [10:0] OY    = 11'(ORIGIN_Y);
    localparam logic signed [10:0] NCOLS = 11'(COLS);
    localparam logic signed [10:0] NROWS = 11'(ROWS);

    logic signed [10:0] rx, ry, cx, cy;

    assign rx = px - OX;
    assign ry = py - OY;
    // Arithmetic shift keeps negative offsets negative so the sign test below
    // still rejects them.
    assign cx = rx >>> SH_X;
    assign cy = ry >>> SH_Y;

    assign valid = !rx[10] && !ry[10] && (cx < NCOLS) && (cy < NROWS);
    assign col   = valid ? cx[4:0] : 5'd0;
    assign row   = valid ? cy[3:0] : 4'd0;

endmodule

// File: rtl/brick_hit_ctrl.sv
// ---------------------------------------------------------------------------
// brick_hit_ctrl
// Brick-map initiator: on each probe, looks up the horizontal and vertical
// lookahead points of the ball, clears any struck brick, reports reflection
// and tracks the bricks left in the stage.
// Ports:
//   clock, reset           clock / async active-high reset
//   start, brick_total     reload brick count, abort any probe
//   probe, ball_*          ball moved: position and direction
//   map_row, map_col       registered map address
//   map_cell               occupied bit of the addressed cell
//   map_enable, map_func   clear command to the map
//   busy, done             FSM activity / one-cycle result strobe
//   hit_x, hit_y           reflect horizontal / vertical velocity
//   score_inc              one pulse per cleared brick
//   bricks_left            bricks remaining
//   stage_clear            level, set when the last brick is cleared
// ---------------------------------------------------------------------------
module brick_hit_ctrl
    import arkanoid_pkg::*;
#(
    parameter int ROWS     = ROWS_DEF,
    parameter int COLS     = COLS_DEF,
    parameter int CELL_W   = 16,
    parameter int CELL_H   = 8,
    parameter int ORIGIN_X = 0,
    parameter int ORIGIN_Y = 0,
    parameter int BALL_R   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [8:0] brick_total,
    input  logic       probe,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic       ball_dx,
    input  logic       ball_dy,
    output logic [3:0] map_row,
    output logic [4:0] map_col,
    input  logic       map_cell,
    output logic       map_enable,
    output logic [1:0] map_func,
    output logic       busy,
    output logic       done,
    output logic       hit_x,
    output logic       hit_y,
    output logic       score_inc,
    output logic [8:0] bricks_left,
    output logic       stage_clear
);

    localparam logic signed [10:0] R_OFF = 11'(BALL_R);

    logic [2:0] state;
    logic [9:0] bx_q, by_q;
    logic       dy_q;
    logic       pt_vld;

    logic signed [10:0] px, py;
    logic [3:0] loc_row;
    logic [4:0] loc_col;
    logic       loc_vld;

    // The locator sees the horizontal point straight from the ball inputs in
    // IDLE (address is registered on probe acceptance), and the vertical point
    // from the latched ball state afterwards.
    always_comb begin
        if (state == ST_IDLE) begin
            px = $signed({1'b0, ball_x}) + (ball_dx ? R_OFF : -R_OFF);
            py = $signed({1'b0, ball_y});
        end else begin
            px = $signed({1'b0, bx_q});
            py = $signed({1'b0, by_q}) + (dy_q ? R_OFF : -R_OFF);
        end
    end

    cell_locator #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .CELL_W  (CELL_W),
        .CELL_H  (CELL_H),
        .ORIGIN_X(ORIGIN_X),
        .ORIGIN_Y(ORIGIN_Y)
    ) u_loc (
        .px   (px),
        .py   (py),
        .row  (loc_row),
        .col  (loc_col),
        .valid(loc_vld)
    );

    // Ball state latch: pure data, no reset needed.
    always_ff @(posedge clock) begin
        if (state == ST_IDLE && probe && !start) begin
            bx_q <= ball_x;
            by_q <= ball_y;
            dy_q <= ball_dy;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            map_row     <= '0;
            map_col     <= '0;
            pt_vld      <= 1'b0;
            hit_x       <= 1'b0;
            hit_y       <= 1'b0;
            bricks_left <= '0;
            stage_clear <= 1'b0;
        end else if (start) begin
            state       <= ST_IDLE;
            hit_x       <= 1'b0;
            hit_y       <= 1'b0;
            bricks_left <= brick_total;
            stage_clear <= (brick_total == 9'd0);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (probe) begin
                        hit_x   <= 1'b0;
                        hit_y   <= 1'b0;
                        map_row <= loc_row;
                        map_col <= loc_col;
                        pt_vld  <= loc_vld;
                        state   <= ST_H_RD;
                    end
                end
                ST_H_RD:  state <= ST_H_CHK;
                ST_H_CHK: begin
                    if (map_cell && pt_vld) begin
                        hit_x <= 1'b1;
                        state <= ST_H_CLR;
                    end else begin
                        map_row <= loc_row;
                        map_col <= loc_col;
                        pt_vld  <= loc_vld;
                        state   <= ST_V_RD;
                    end
                end
                ST_H_CLR: begin
                    bricks_left <= sat_dec(bricks_left);
                    if (bricks_left == 9'd1) stage_clear <= 1'b1;
                    map_row <= loc_row;
                    map_col <= loc_col;
                    pt_vld  <= loc_vld;
                    state   <= ST_V_RD;
                end
                ST_V_RD:  state <= ST_V_CHK;
                ST_V_CHK: begin
                    if (map_cell && pt_vld) begin
                        hit_y <= 1'b1;
                        state <= ST_V_CLR;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_V_CLR: begin
                    bricks_left <= sat_dec(bricks_left);
                    if (bricks_left == 9'd1) stage_clear <= 1'b1;
                    state <= ST_DONE;
                end
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // CLR states are only reachable for a valid, occupied point.
    assign map_enable = (state == ST_H_CLR) || (state == ST_V_CLR);
    assign score_inc  = map_enable;
    assign map_func   = FUNC_CLEAR;
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);

endmodule
